// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state encoding, owner codes and abort data for the SRAM arbiter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] OWN_CPU = 2'd0;
    localparam logic [1:0] OWN_DMA = 2'd1;
    localparam logic [1:0] OWN_VID = 2'd2;

    localparam logic [7:0] RDATA_ABORT = 8'hFF;

endpackage

// File: rtl/sram_rr_pick.sv
// rtl/sram_rr_pick.sv - 2-way round-robin picker; ptr=0 favours req[0] (CPU), ptr=1 favours req[1] (DMA)
module sram_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_next_ptr
);

    // The pointer always moves to favour the port that did not just win.
    always_comb begin
        o_grant    = 2'b00;
        o_next_ptr = i_ptr;
        if (i_req[0] && (!i_req[1] || !i_ptr)) begin
            o_grant    = 2'b01;
            o_next_ptr = 1'b1;
        end else if (i_req[1]) begin
            o_grant    = 2'b10;
            o_next_ptr = 1'b0;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - single-SRAM arbiter for CPU/DMA (and video when SRAM_VIDEO_PORT_EN is defined)
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W         = 19,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_wait,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
`ifdef SRAM_VIDEO_PORT_EN
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              err_clr,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_owner;
    logic              r_we;
    logic              r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        w_grant;
    logic              w_next_ptr;
    logic              w_vid_req;
    logic              w_abort;

`ifdef SRAM_VIDEO_PORT_EN
    assign w_vid_req = vid_req;
    assign vid_ack   = (r_state == ST_DONE) && (r_owner == OWN_VID);
`else
    assign w_vid_req = 1'b0;
`endif

    sram_rr_pick u_pick (
        .i_req      ({dma_req, cpu_req}),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_next_ptr (w_next_ptr)
    );

    always_comb begin
        w_next_state = r_state;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vid_req || (w_grant != 2'b00)) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // A late ready on the final counted cycle still completes normally.
                if (mem_ready) begin
                    w_next_state = ST_DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_CPU;
            r_we        <= 1'b0;
            r_ptr       <= 1'b0;
            r_cnt       <= '0;
            rdata       <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rd      <= 1'b0;
            mem_we      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
`ifdef SRAM_VIDEO_PORT_EN
                    if (vid_req) begin
                        r_owner  <= OWN_VID;
                        mem_addr <= vid_addr;
                        r_we     <= 1'b0;
                        mem_rd   <= 1'b1;
                        mem_we   <= 1'b0;
                    end else
`endif
                    if (w_grant[0]) begin
                        r_owner   <= OWN_CPU;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        r_we      <= cpu_we;
                        mem_rd    <= ~cpu_we;
                        mem_we    <= cpu_we;
                        r_ptr     <= w_next_ptr;
                    end else if (w_grant[1]) begin
                        r_owner   <= OWN_DMA;
                        mem_addr  <= dma_addr;
                        mem_wdata <= dma_wdata;
                        r_we      <= dma_we;
                        mem_rd    <= ~dma_we;
                        mem_we    <= dma_we;
                        r_ptr     <= w_next_ptr;
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mem_ready) begin
                        if (!r_we) begin
                            rdata <= mem_rdata;
                        end
                    end else if (w_abort) begin
                        rdata <= DATA_W'(RDATA_ABORT);
                    end
                    if (w_next_state == ST_DONE) begin
                        mem_rd <= 1'b0;
                        mem_we <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (w_abort) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign cpu_ack  = (r_state == ST_DONE) && (r_owner == OWN_CPU);
    assign dma_ack  = (r_state == ST_DONE) && (r_owner == OWN_DMA);
    assign cpu_wait = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter (video cases when SRAM_VIDEO_PORT_EN is defined)
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_ack, cpu_wait;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        dma_req, dma_we, dma_ack;
    logic [18:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        vid_ack;
`ifdef SRAM_VIDEO_PORT_EN
    logic        vid_req;
    logic [18:0] vid_addr;
`else
    assign vid_ack = 1'b0;
`endif
    logic [7:0]  rdata;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd, mem_we, mem_ready;
    logic [7:0]  mem_rdata;
    logic        err_clr, timeout_err;

    logic        ready_en;
    logic [7:0]  rd_val;

    assign mem_ready = ready_en & (mem_rd | mem_we);
    assign mem_rdata = rd_val;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_wait    (cpu_wait),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_ack     (dma_ack),
`ifdef SRAM_VIDEO_PORT_EN
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_ack     (vid_ack),
`endif
        .rdata       (rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .err_clr     (err_clr),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic [1:0] own;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [1:0] mon_own;
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ack(input logic [1:0] own, input logic [7:0] d);
        exp_t e;
        e.own  = own;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        tick;
        while (!(cpu_ack | dma_ack | vid_ack) && n < 40) begin
            tick;
            n++;
        end
        if (!(cpu_ack | dma_ack | vid_ack)) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: no ack within 40 cycles", name);
        end
    endtask

    // Scoreboard monitor: every ack pops the oldest expected response.
    always @(negedge clk) begin
        if (!reset) begin
            check("cpu_wait", {31'b0, cpu_wait}, {31'b0, cpu_req & ~cpu_ack});
        end
        if (cpu_ack | dma_ack | vid_ack) begin
            check("one_ack", {30'b0, 2'(cpu_ack) + 2'(dma_ack) + 2'(vid_ack)}, 32'd1);
            mon_own = cpu_ack ? 2'd0 : (dma_ack ? 2'd1 : 2'd2);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_ack: owner %0d with no expected response queued", mon_own);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_owner", {30'b0, mon_own}, {30'b0, mon_e.own});
                check("ack_rdata", {24'b0, rdata}, {24'b0, mon_e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n;

    initial begin
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
`ifdef SRAM_VIDEO_PORT_EN
        vid_req = 1'b0; vid_addr = '0;
`endif
        err_clr = 1'b0; ready_en = 1'b1; rd_val = '0;

        // Reset state with CPU already requesting
        tick;
        tick;
        check("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_cpu_ack", {31'b0, cpu_ack}, 32'd0);
        check("rst_dma_ack", {31'b0, dma_ack}, 32'd0);
        check("rst_cpu_wait", {31'b0, cpu_wait}, 32'd1);
        check("rst_mem_addr", {13'b0, mem_addr}, 32'd0);
        check("rst_rdata", {24'b0, rdata}, 32'd0);
        check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        cpu_req = 1'b0;
        reset   = 1'b0;
        tick;

        // Zero-wait CPU read
        cpu_we = 1'b0; cpu_addr = 19'h12345; rd_val = 8'hA5;
        expect_ack(2'd0, 8'hA5);
        cpu_req = 1'b1;
        tick;
        check("t2_mem_rd", {31'b0, mem_rd}, 32'd1);
        check("t2_mem_addr", {13'b0, mem_addr}, 32'h12345);
        check("t2_early_ack", {31'b0, cpu_ack}, 32'd0);
        tick;
        check("t2_cpu_ack", {31'b0, cpu_ack}, 32'd1);
        check("t2_mem_rd_low", {31'b0, mem_rd}, 32'd0);
        check("t2_cpu_wait_low", {31'b0, cpu_wait}, 32'd0);
        cpu_req = 1'b0;
        tick;
        tick;

        // CPU and DMA both held: C,D,C,D
        pulse_reset;
        cpu_we = 1'b0; cpu_addr = 19'h00ABC;
        dma_we = 1'b1; dma_addr = 19'h00777; dma_wdata = 8'h3C;
        expect_ack(2'd0, 8'h10);
        expect_ack(2'd1, 8'h10);
        expect_ack(2'd0, 8'h12);
        expect_ack(2'd1, 8'h12);
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rd_val = 8'(16 + k);
            tick;
            if (k % 2 == 0) begin
                check("t3_cpu_rd", {31'b0, mem_rd}, 32'd1);
                check("t3_cpu_addr", {13'b0, mem_addr}, 32'h00ABC);
            end else begin
                check("t3_dma_we", {31'b0, mem_we}, 32'd1);
                check("t3_dma_rd", {31'b0, mem_rd}, 32'd0);
                check("t3_dma_wdata", {24'b0, mem_wdata}, 32'h3C);
                check("t3_dma_addr", {13'b0, mem_addr}, 32'h00777);
            end
            tick;
            if (k == 3) begin
                cpu_req = 1'b0;
                dma_req = 1'b0;
            end else begin
                tick;
            end
        end
        tick;

        // Timeout abort on a DMA read
        ready_en = 1'b0;
        dma_we = 1'b0; dma_addr = 19'h04000;
        expect_ack(2'd1, 8'hFF);
        dma_req = 1'b1;
        tick;
        n = 0;
        while (mem_rd && n < 40) begin
            n++;
            tick;
        end
        check("t4_access_cycles", n, 32'd16);
        check("t4_dma_ack", {31'b0, dma_ack}, 32'd1);
        check("t4_err_set", {31'b0, timeout_err}, 32'd1);
        dma_req = 1'b0;
        tick;
        tick;
        check("t4_err_sticky", {31'b0, timeout_err}, 32'd1);
        expect_ack(2'd1, 8'hFF);
        dma_req = 1'b1;
        tick;
        repeat (15) tick;
        check("t4_last_access", {31'b0, mem_rd}, 32'd1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        check("t4_set_wins", {31'b0, timeout_err}, 32'd1);
        check("t4_dma_ack2", {31'b0, dma_ack}, 32'd1);
        dma_req = 1'b0;
        tick;
        check("t4_err_before_clr", {31'b0, timeout_err}, 32'd1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        check("t4_err_cleared", {31'b0, timeout_err}, 32'd0);
        ready_en = 1'b1;

        // Reset in the second ACCESS cycle of a CPU write
        pulse_reset;
        ready_en = 1'b0;
        cpu_we = 1'b1; cpu_addr = 19'h7FFFF; cpu_wdata = 8'h99;
        cpu_req = 1'b1;
        tick;
        check("t5_mem_we", {31'b0, mem_we}, 32'd1);
        tick;
        #2;
        reset = 1'b1;
        #1;
        check("t5_we_async_drop", {31'b0, mem_we}, 32'd0);
        check("t5_no_ack", {31'b0, cpu_ack}, 32'd0);
        tick;
        reset = 1'b0;
        ready_en = 1'b1;
        expect_ack(2'd0, 8'h00);
        tick;
        check("t5_retry_we", {31'b0, mem_we}, 32'd1);
        check("t5_retry_wdata", {24'b0, mem_wdata}, 32'h99);
        check("t5_retry_addr", {13'b0, mem_addr}, 32'h7FFFF);
        tick;
        check("t5_retry_ack", {31'b0, cpu_ack}, 32'd1);
        cpu_req = 1'b0;
        tick;

        // Priority with all ports requesting
        pulse_reset;
        cpu_we = 1'b0; dma_we = 1'b0;
        cpu_addr = 19'h00100; dma_addr = 19'h00200;
`ifdef SRAM_VIDEO_PORT_EN
        vid_addr = 19'h50000;
        expect_ack(2'd2, 8'h20);
        expect_ack(2'd0, 8'h21);
        expect_ack(2'd1, 8'h22);
        expect_ack(2'd2, 8'h23);
        vid_req = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rd_val = 8'(32 + k);
            wait_ack("t6_vid_ack_wait");
            if (k == 0) vid_req = 1'b0;
            if (k == 2) vid_req = 1'b1;
            if (k == 3) begin
                vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
            end
            tick;
        end
`else
        expect_ack(2'd0, 8'h20);
        expect_ack(2'd1, 8'h21);
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd_val = 8'(32 + k);
            wait_ack("t6_ack_wait");
            if (k == 1) begin
                cpu_req = 1'b0; dma_req = 1'b0;
            end
            tick;
        end
`endif
        tick;
        tick;
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
